lsu: RTL

Load/store unit between the execute stage and the data-memory port. It accepts one load or store at a time from the core, drives a request/grant/rvalid memory handshake with word-aligned address and byte enables, and returns aligned, sign/zero-extended load data. That data is the `mem_rdata` source for the write-back mux. Misaligned or illegal accesses are reported as errors without touching memory.

---
 rtl/lsu.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/lsu.sv
// Load/store unit: one access at a time from the core, driven over a
// req/gnt/rvalid data-memory handshake. Load data is returned aligned and extended.
module lsu #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic                    req_we_i,
  input  logic [2:0]              req_funct3_i,
  input  logic [ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [DATA_WIDTH-1:0]   req_wdata_i,
  output logic                    rsp_valid_o,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic                    rsp_err_o,
  output logic                    mem_req_o,
  input  logic                    mem_gnt_i,
  output logic                    mem_we_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic                    mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    RESP
  } state_e;

  state_e                  state_q, state_d;
  logic                    mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [BE_WIDTH-1:0]     mem_be_q, mem_be_d;
  logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
  logic [2:0]              funct3_q, funct3_d;
  logic [1:0]              off_q, off_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic                    rsp_err_q, rsp_err_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;

  logic [1:0]              req_off;
  logic                    req_illegal;
  logic                    req_misaligned;
  logic                    req_err;
  logic [BE_WIDTH-1:0]     req_be;
  logic [DATA_WIDTH-1:0]   req_wdata_rep;
  logic [DATA_WIDTH-1:0]   load_shifted;
  logic [DATA_WIDTH-1:0]   load_data;

  // Decode of the incoming request: legality, alignment, lanes and store data.
  always_comb begin
    req_off        = req_addr_i[1:0];
    req_illegal    = 1'b0;
    req_misaligned = 1'b0;
    req_be         = '0;
    req_wdata_rep  = req_wdata_i;

    if (req_we_i) begin
      req_illegal = (req_funct3_i > 3'd2);
    end else begin
      req_illegal = (req_funct3_i == 3'd3) || (req_funct3_i >= 3'd6);
    end

    case (req_funct3_i[1:0])
      2'd1:    req_misaligned = req_off[0];
      2'd2:    req_misaligned = (req_off != 2'd0);
      default: req_misaligned = 1'b0;
    endcase

    req_err = req_illegal || req_misaligned;

    case (req_funct3_i[1:0])
      2'd0: begin
        req_be        = 4'b0001 << req_off;
        req_wdata_rep = {4{req_wdata_i[7:0]}};
      end
      2'd1: begin
        req_be        = 4'b0011 << req_off;
        req_wdata_rep = {2{req_wdata_i[15:0]}};
      end
      default: begin
        req_be        = 4'b1111;
        req_wdata_rep = req_wdata_i;
      end
    endcase
  end

  // Right-align the addressed bytes, then extend according to the load type.
  always_comb begin
    load_shifted = mem_rdata_i >> {off_q, 3'b000};
    case (funct3_q)
      3'd0:    load_data = {{24{load_shifted[7]}}, load_shifted[7:0]};
      3'd1:    load_data = {{16{load_shifted[15]}}, load_shifted[15:0]};
      3'd4:    load_data = {24'd0, load_shifted[7:0]};
      3'd5:    load_data = {16'd0, load_shifted[15:0]};
      default: load_data = load_shifted;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    funct3_d    = funct3_q;
    off_d       = off_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = rsp_rdata_q;

    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          funct3_d = req_funct3_i;
          off_d    = req_off;
          if (req_err) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end else begin
            state_d     = REQ;
            mem_we_d    = req_we_i;
            mem_addr_d  = {req_addr_i[ADDR_WIDTH-1:2], 2'b00};
            mem_be_d    = req_be;
            mem_wdata_d = req_wdata_rep;
          end
        end
      end
      REQ: begin
        // An rvalid coinciding with the grant is not a response and is dropped.
        if (mem_gnt_i) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (mem_rvalid_i) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = mem_we_q ? '0 : load_data;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      funct3_q    <= 3'd0;
      off_q       <= 2'd0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      funct3_q    <= funct3_d;
      off_q       <= off_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign req_ready_o = rst_ni && (state_q == IDLE);
  assign mem_req_o   = (state_q == REQ);
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_be_o    = mem_be_q;
  assign mem_wdata_o = mem_wdata_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_err_o   = rsp_err_q;
  assign rsp_rdata_o = rsp_rdata_q;

endmodule
